// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state type and default geometry for wait_state_memory
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 128;
    localparam int BE_W       = DEF_DATA_W / 8;
    localparam int OFF_W      = $clog2(BE_W);
    localparam int IDX_W      = $clog2(DEF_DEPTH);

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word RAM with per-byte write enable, registered read, no reset
//
// Ports:
//   clk    clock
//   en     access strobe for this cycle
//   we     1 = write the enabled bytes, 0 = read into rdata
//   addr   word index
//   be     byte enables, one per 8-bit lane
//   wdata  write data
//   rdata  read data, updated only on a read access
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic                             clk,
    input  logic                             en,
    input  logic                             we,
    input  logic [$clog2(DEPTH)-1:0]         addr,
    input  logic [DATA_W/8-1:0]              be,
    input  logic [DATA_W-1:0]                wdata,
    output logic [DATA_W-1:0]                rdata
);

    logic [DATA_W-1:0] memory [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (be[i]) begin
                        memory[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= memory[addr];
            end
        end
    end

endmodule

// File: rtl/wait_state_memory.sv
// rtl/wait_state_memory.sv - word RAM behind valid/ready request/response with wait states and error reporting
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we/req_addr/req_wdata/req_be request payload (byte address, byte enables)
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata/rsp_err               response payload
//   stat_reads/stat_writes/stat_errs access counters, present only with MEM_STATS_EN defined
module wait_state_memory
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]         stat_reads,
    output logic [31:0]         stat_writes,
    output logic [31:0]         stat_errs
`endif
);

    localparam int BYTES    = DATA_W / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int IDX_BITS = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);

    state_t            state, state_n;
    logic [3:0]        wcnt, wcnt_n;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BYTES-1:0]  be_q;
    logic              zero_q;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BYTES-1:0]  acc_be;
    logic [ADDR_W-1:0] acc_word;
    logic              acc_err;
    logic              enter_resp;
    logic [DATA_W-1:0] ram_rdata;

    // With zero wait states the array is accessed on the accept edge itself,
    // so the access uses the live request; otherwise the latched copy.
    always_comb begin
        acc_we    = (state == IDLE) ? req_we    : we_q;
        acc_addr  = (state == IDLE) ? req_addr  : addr_q;
        acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
        acc_be    = (state == IDLE) ? req_be    : be_q;
        acc_word  = acc_addr >> OFF_BITS;
        // No wrap-around: any word index at or beyond DEPTH is an error.
        acc_err   = ((acc_addr & OFF_MASK) != '0) || (64'(acc_word) >= 64'(DEPTH));
    end

    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        wcnt_n  = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (wcnt == 4'd0) begin
                    state_n = RESP;
                end else begin
                    wcnt_n = wcnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign enter_resp = (state_n == RESP) && (state != RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wcnt    <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rsp_err <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (enter_resp) begin
                rsp_err <= acc_err;
                zero_q  <= acc_err || acc_we;
            end
        end
    end

    // The RAM output register is not reset; zero_q masks it for writes,
    // errors and the post-reset state.
    assign rsp_rdata = zero_q ? '0 : ram_rdata;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (enter_resp && !acc_err),
        .we    (acc_we),
        .addr  (acc_word[IDX_BITS-1:0]),
        .be    (acc_be),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reads  <= 32'd0;
            stat_writes <= 32'd0;
            stat_errs   <= 32'd0;
        end else if (enter_resp) begin
            if (acc_err) begin
                stat_errs <= stat_errs + 32'd1;
            end else if (acc_we) begin
                stat_writes <= stat_writes + 32'd1;
            end else begin
                stat_reads <= stat_reads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wait_state_memory.sv
// tb/tb_wait_state_memory.sv - scoreboard bench for wait_state_memory at 0, 1 and 3 wait states
module tb_wait_state_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [15:0] req_addr  [3];
    logic [15:0] req_wdata [3];
    logic [1:0]  req_be    [3];
    logic        rsp_ready [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [15:0] rsp_rdata [3];
    logic        rsp_err   [3];
`ifdef MEM_STATS_EN
    logic [31:0] stat_reads  [3];
    logic [31:0] stat_writes [3];
    logic [31:0] stat_errs   [3];
`endif

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // index 0: WAIT_STATES=1, index 1: WAIT_STATES=0, index 2: WAIT_STATES=3
    wait_state_memory #(.WAIT_STATES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef MEM_STATS_EN
        , .stat_reads(stat_reads[0]), .stat_writes(stat_writes[0]), .stat_errs(stat_errs[0])
`endif
    );

    wait_state_memory #(.WAIT_STATES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef MEM_STATS_EN
        , .stat_reads(stat_reads[1]), .stat_writes(stat_writes[1]), .stat_errs(stat_errs[1])
`endif
    );

    wait_state_memory #(.WAIT_STATES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
`ifdef MEM_STATS_EN
        , .stat_reads(stat_reads[2]), .stat_writes(stat_writes[2]), .stat_errs(stat_errs[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction, entered and left #1 after a posedge.
    task automatic access(input int d, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be,
                          input int exp_lat, input logic [15:0] exp_rdata,
                          input bit exp_err, input int hold);
        exp_t e;
        int   lat;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        chk("req_ready_before_accept", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat <= 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        e = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata[d]), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_rsp_valid", 32'(rsp_valid[d]), 32'd1);
            chk("hold_rsp_rdata", 32'(rsp_rdata[d]), 32'(e.rdata));
            chk("hold_rsp_err", 32'(rsp_err[d]), 32'(e.err));
            chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        chk("rsp_valid_after_consume", 32'(rsp_valid[d]), 32'd0);
        chk("req_ready_after_consume", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 16'h0;
            req_wdata[i] = 16'h0;
            req_be[i]    = 2'b00;
            rsp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready[0]), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata[0]), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err[0]), 32'd0);
        u_w1.u_array.memory[0] = 16'hA101;
        u_w1.u_array.memory[2] = 16'hFFFF;
        u_w0.u_array.memory[1] = 16'h0B0B;
        u_w3.u_array.memory[0] = 16'hC3C3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic read, byte-enable write, read-back
        access(0, 1'b0, 16'd0, 16'h0, 2'b00, 2, 16'hA101, 1'b0, 0);
        access(0, 1'b1, 16'd4, 16'h1234, 2'b10, 2, 16'h0000, 1'b0, 0);
        access(0, 1'b0, 16'd4, 16'h0, 2'b00, 2, 16'h12FF, 1'b0, 0);

        // errors: misaligned, out of range read and write, no side effects
        access(0, 1'b0, 16'd3, 16'h0, 2'b00, 2, 16'h0000, 1'b1, 0);
        access(0, 1'b0, 16'd256, 16'h0, 2'b00, 2, 16'h0000, 1'b1, 0);
        access(0, 1'b1, 16'd256, 16'h5555, 2'b11, 2, 16'h0000, 1'b1, 0);
        access(0, 1'b1, 16'd5, 16'h5555, 2'b11, 2, 16'h0000, 1'b1, 0);
        access(0, 1'b0, 16'd0, 16'h0, 2'b00, 2, 16'hA101, 1'b0, 0);
        access(0, 1'b0, 16'd4, 16'h0, 2'b00, 2, 16'h12FF, 1'b0, 0);

        // all-zero byte enables: response issued, word unchanged
        access(0, 1'b1, 16'd4, 16'h0000, 2'b00, 2, 16'h0000, 1'b0, 0);
        access(0, 1'b0, 16'd4, 16'h0, 2'b00, 2, 16'h12FF, 1'b0, 0);

        // zero and three wait states
        access(1, 1'b0, 16'd2, 16'h0, 2'b00, 1, 16'h0B0B, 1'b0, 0);
        access(1, 1'b1, 16'd2, 16'h7788, 2'b01, 1, 16'h0000, 1'b0, 0);
        access(1, 1'b0, 16'd2, 16'h0, 2'b00, 1, 16'h0B88, 1'b0, 0);
        access(2, 1'b0, 16'd0, 16'h0, 2'b00, 4, 16'hC3C3, 1'b0, 0);
        access(2, 1'b0, 16'd255, 16'h0, 2'b00, 4, 16'h0000, 1'b1, 0);

        // response held back for 5 cycles
        access(0, 1'b0, 16'd4, 16'h0, 2'b00, 2, 16'h12FF, 1'b0, 5);
        access(0, 1'b0, 16'd3, 16'h0, 2'b00, 2, 16'h0000, 1'b1, 5);

        // reset while a write sits in WAIT
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 16'd0;
        req_wdata[0] = 16'hBEEF;
        req_be[0]    = 2'b11;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("in_wait_req_ready", 32'(req_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
`ifdef MEM_STATS_EN
        chk("stat_reads_reset", stat_reads[0], 32'd0);
        chk("stat_writes_reset", stat_writes[0], 32'd0);
        chk("stat_errs_reset", stat_errs[0], 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1'b0, 16'd0, 16'h0, 2'b00, 2, 16'hA101, 1'b0, 0);
`ifdef MEM_STATS_EN
        access(0, 1'b1, 16'd6, 16'h0101, 2'b11, 2, 16'h0000, 1'b0, 0);
        access(0, 1'b0, 16'd1, 16'h0, 2'b00, 2, 16'h0000, 1'b1, 0);
        chk("stat_reads", stat_reads[0], 32'd1);
        chk("stat_writes", stat_writes[0], 32'd1);
        chk("stat_errs", stat_errs[0], 32'd1);
`endif
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
